// File: rtl/csr_access_seq.sv
// Machine-mode CSR access sequencer: runs CSRRW/RS/RC, ECALL and MRET as fixed
// multi-cycle sequences against the CSR file on behalf of decode.
module csr_access_seq #(
   parameter int          XLEN       = 32,
   parameter logic [11:0] MTVEC_ADDR = 12'h305,
   parameter logic [11:0] MEPC_ADDR  = 12'h341
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [2:0]      op,
   input  logic            imm_sel,
   input  logic [11:0]     csr,
   input  logic [4:0]      rs1_idx,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [4:0]      uimm,
   input  logic [XLEN-1:0] pc,
   output logic            busy,
   output logic            done,
   output logic            rd_we,
   output logic [XLEN-1:0] rd_data,
   output logic            redirect,
   output logic [XLEN-1:0] redirect_pc,
   output logic            illegal,
   output logic [11:0]     csr_addr,
   input  logic [XLEN-1:0] csr_rdata,
   output logic [11:0]     wr_addr,
   output logic [XLEN-1:0] wr_data,
   output logic            wcsr_n,
   output logic            ecall_o,
   output logic            mret_o,
   output logic [XLEN-1:0] epc_out
);

   localparam logic [2:0] OP_RW    = 3'b001;
   localparam logic [2:0] OP_RS    = 3'b010;
   localparam logic [2:0] OP_RC    = 3'b011;
   localparam logic [2:0] OP_ECALL = 3'b100;
   localparam logic [2:0] OP_MRET  = 3'b101;

   typedef enum logic [2:0] {
      IDLE, CSR_RD, CSR_WR, TRAP_RD, TRAP_WR, MRET_RD, MRET_WR, DONE
   } state_t;

   state_t            state;
   logic [2:0]        op_q;
   logic              imm_sel_q;
   logic [11:0]       csr_q;
   logic [4:0]        rs1_idx_q;
   logic [XLEN-1:0]   rs1_data_q;
   logic [4:0]        uimm_q;
   logic [XLEN-1:0]   pc_q;
   logic [XLEN-1:0]   old_q;
   logic [XLEN-1:0]   target_q;

   logic [XLEN-1:0]   src;
   logic [XLEN-1:0]   new_val;
   logic              src_zero;
   logic              suppress;
   logic              read_only;
   logic              addr_ok;

   // new_val is formed from the live read data during CSR_RD, so the write
   // data is ready to register on the same edge that captures old_q.
   always_comb begin
      src       = imm_sel_q ? {{(XLEN-5){1'b0}}, uimm_q} : rs1_data_q;
      src_zero  = imm_sel_q ? (uimm_q == 5'd0) : (rs1_idx_q == 5'd0);
      suppress  = ((op_q == OP_RS) || (op_q == OP_RC)) && src_zero;
      read_only = (csr_q[11:10] == 2'b11);
      addr_ok   = csr_q inside {12'h300, 12'h304, 12'h305, 12'h340,
                                12'h341, 12'h342, 12'h343, 12'h344};
      case (op_q)
         OP_RS:   new_val = csr_rdata | src;
         OP_RC:   new_val = csr_rdata & ~src;
         default: new_val = src;
      endcase
   end

   // All outputs are registered on entry to the state that owns them, so
   // each strobe is held for exactly one full clock period.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         op_q        <= '0;
         imm_sel_q   <= 1'b0;
         csr_q       <= '0;
         rs1_idx_q   <= '0;
         rs1_data_q  <= '0;
         uimm_q      <= '0;
         pc_q        <= '0;
         old_q       <= '0;
         target_q    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         rd_we       <= 1'b0;
         rd_data     <= '0;
         redirect    <= 1'b0;
         redirect_pc <= '0;
         illegal     <= 1'b0;
         csr_addr    <= '0;
         wr_addr     <= '0;
         wr_data     <= '0;
         wcsr_n      <= 1'b1;
         ecall_o     <= 1'b0;
         mret_o      <= 1'b0;
         epc_out     <= '0;
      end else begin
         done     <= 1'b0;
         rd_we    <= 1'b0;
         redirect <= 1'b0;
         wcsr_n   <= 1'b1;
         ecall_o  <= 1'b0;
         mret_o   <= 1'b0;
         csr_addr <= '0;
         wr_addr  <= '0;
         wr_data  <= '0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_q       <= op;
                  imm_sel_q  <= imm_sel;
                  csr_q      <= csr;
                  rs1_idx_q  <= rs1_idx;
                  rs1_data_q <= rs1_data;
                  uimm_q     <= uimm;
                  pc_q       <= pc;
                  busy       <= 1'b1;
                  case (op)
                     OP_RW, OP_RS, OP_RC: begin
                        state    <= CSR_RD;
                        csr_addr <= csr;
                     end
                     OP_ECALL: begin
                        state    <= TRAP_RD;
                        csr_addr <= MTVEC_ADDR;
                     end
                     OP_MRET: begin
                        state    <= MRET_RD;
                        csr_addr <= MEPC_ADDR;
                     end
                     default: begin
                        state   <= DONE;
                        done    <= 1'b1;
                        illegal <= 1'b1;
                     end
                  endcase
               end
            end
            CSR_RD: begin
               old_q <= csr_rdata;
               if (!addr_ok) begin
                  state   <= DONE;
                  done    <= 1'b1;
                  illegal <= 1'b1;
               end else begin
                  state   <= CSR_WR;
                  wr_addr <= csr_q;
                  wr_data <= new_val;
                  wcsr_n  <= suppress || read_only;
               end
            end
            CSR_WR: begin
               state <= DONE;
               done  <= 1'b1;
               if (read_only && !suppress) begin
                  illegal <= 1'b1;
               end else begin
                  illegal <= 1'b0;
                  rd_we   <= 1'b1;
                  rd_data <= old_q;
               end
            end
            TRAP_RD: begin
               target_q <= {csr_rdata[XLEN-1:2], 2'b00};
               state    <= TRAP_WR;
               ecall_o  <= 1'b1;
               epc_out  <= pc_q;
            end
            MRET_RD: begin
               target_q <= csr_rdata;
               state    <= MRET_WR;
               mret_o   <= 1'b1;
            end
            TRAP_WR, MRET_WR: begin
               state       <= DONE;
               done        <= 1'b1;
               redirect    <= 1'b1;
               redirect_pc <= target_q;
               illegal     <= 1'b0;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_csr_access_seq.sv
// Self-checking bench for csr_access_seq: directed scenarios plus randomized
// requests, judged against a transaction-level model of the CSR file.
module tb_csr_access_seq;

   localparam logic [2:0] OP_RW    = 3'b001;
   localparam logic [2:0] OP_RS    = 3'b010;
   localparam logic [2:0] OP_RC    = 3'b011;
   localparam logic [2:0] OP_ECALL = 3'b100;
   localparam logic [2:0] OP_MRET  = 3'b101;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [2:0]  op;
   logic        imm_sel;
   logic [11:0] csr;
   logic [4:0]  rs1_idx;
   logic [31:0] rs1_data;
   logic [4:0]  uimm;
   logic [31:0] pc;
   logic        busy, done, rd_we, redirect, illegal, wcsr_n, ecall_o, mret_o;
   logic [31:0] rd_data, redirect_pc, csr_rdata, wr_data, epc_out;
   logic [11:0] csr_addr, wr_addr;

   logic [31:0] csr_mem [0:4095];
   int          wr_cnt, ecall_cnt, mret_cnt;
   logic [11:0] last_wr_addr;
   logic [31:0] last_wr_data, last_epc;
   int          tests, fails;

   typedef struct {
      int          lat;
      logic        ill;
      logic        rdwe;
      logic [31:0] rdd;
      logic        redir;
      logic [31:0] rpc;
      int          wrs;
      logic [31:0] wval;
      int          ecalls;
      int          mrets;
   } exp_t;

   csr_access_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .imm_sel(imm_sel),
      .csr(csr), .rs1_idx(rs1_idx), .rs1_data(rs1_data), .uimm(uimm), .pc(pc),
      .busy(busy), .done(done), .rd_we(rd_we), .rd_data(rd_data),
      .redirect(redirect), .redirect_pc(redirect_pc), .illegal(illegal),
      .csr_addr(csr_addr), .csr_rdata(csr_rdata), .wr_addr(wr_addr),
      .wr_data(wr_data), .wcsr_n(wcsr_n), .ecall_o(ecall_o), .mret_o(mret_o),
      .epc_out(epc_out)
   );

   always #5 clk = ~clk;

   assign csr_rdata = csr_mem[csr_addr];

   // Negedge step that also plays the CSR file's capture of writes and strobes
   task automatic tick();
      @(negedge clk);
      if (!wcsr_n) begin
         csr_mem[wr_addr] = wr_data;
         wr_cnt++;
         last_wr_addr = wr_addr;
         last_wr_data = wr_data;
      end
      if (ecall_o) begin
         ecall_cnt++;
         last_epc = epc_out;
      end
      if (mret_o) mret_cnt++;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   function automatic exp_t predict(input logic [2:0] o, input bit im,
                                    input logic [11:0] c, input logic [4:0] ri,
                                    input logic [31:0] rd, input logic [4:0] u);
      exp_t        e;
      logic [31:0] old, src, nv;
      bit          sup;
      e = '{lat: 1, ill: 1'b1, rdwe: 1'b0, rdd: 32'h0, redir: 1'b0, rpc: 32'h0,
            wrs: 0, wval: 32'h0, ecalls: 0, mrets: 0};
      if (o == OP_ECALL) begin
         e.lat = 3; e.ill = 1'b0; e.redir = 1'b1; e.ecalls = 1;
         e.rpc = csr_mem[12'h305] & 32'hFFFF_FFFC;
      end else if (o == OP_MRET) begin
         e.lat = 3; e.ill = 1'b0; e.redir = 1'b1; e.mrets = 1;
         e.rpc = csr_mem[12'h341];
      end else if (o == OP_RW || o == OP_RS || o == OP_RC) begin
         if (!(c inside {12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                         12'h342, 12'h343, 12'h344})) begin
            e.lat = 2;
         end else begin
            old = csr_mem[c];
            src = im ? {27'b0, u} : rd;
            nv  = (o == OP_RW) ? src : (o == OP_RS) ? (old | src) : (old & ~src);
            sup = (o != OP_RW) && ((im ? u : ri) == 5'd0);
            e.lat = 3;
            if (c[11:10] == 2'b11 && !sup) begin
               e.ill = 1'b1;
            end else begin
               e.ill = 1'b0; e.rdwe = 1'b1; e.rdd = old;
               e.wrs = sup ? 0 : 1; e.wval = nv;
            end
         end
      end
      return e;
   endfunction

   // Runs one request from an IDLE negedge to the IDLE negedge after DONE.
   // With poke set, start is re-asserted through busy and DONE to prove it is ignored.
   task automatic applyStimulus(input string tag, input logic [2:0] o, input bit im,
                                input logic [11:0] c, input logic [4:0] ri,
                                input logic [31:0] rd, input logic [4:0] u,
                                input logic [31:0] p, input bit poke);
      exp_t e;
      int   w0, ec0, mr0, k;
      bit   seen;
      e = predict(o, im, c, ri, rd, u);
      w0 = wr_cnt; ec0 = ecall_cnt; mr0 = mret_cnt;
      start = 1'b1; op = o; imm_sel = im; csr = c; rs1_idx = ri;
      rs1_data = rd; uimm = u; pc = p;
      @(posedge clk); #1;
      start = poke;
      if (poke) op = OP_ECALL;
      k = 0; seen = 0;
      while (!seen && k < 10) begin
         tick();
         k++;
         if (k == 1) checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd1);
         if (done) seen = 1;
         else begin @(posedge clk); #1; end
      end
      checkOutput({tag, ".latency"}, k, e.lat);
      checkOutput({tag, ".illegal"}, {31'b0, illegal}, {31'b0, e.ill});
      checkOutput({tag, ".rd_we"}, {31'b0, rd_we}, {31'b0, e.rdwe});
      if (e.rdwe) checkOutput({tag, ".rd_data"}, rd_data, e.rdd);
      checkOutput({tag, ".redirect"}, {31'b0, redirect}, {31'b0, e.redir});
      if (e.redir) checkOutput({tag, ".redirect_pc"}, redirect_pc, e.rpc);
      checkOutput({tag, ".writes"}, wr_cnt - w0, e.wrs);
      if (e.wrs > 0) begin
         checkOutput({tag, ".wr_addr"}, {20'b0, last_wr_addr}, {20'b0, c});
         checkOutput({tag, ".wr_data"}, last_wr_data, e.wval);
      end
      checkOutput({tag, ".ecalls"}, ecall_cnt - ec0, e.ecalls);
      if (e.ecalls > 0) checkOutput({tag, ".epc_out"}, last_epc, p);
      checkOutput({tag, ".mrets"}, mret_cnt - mr0, e.mrets);
      @(posedge clk); #1;
      start = 1'b0; op = o;
      tick();
      checkOutput({tag, ".idle_done"}, {31'b0, done}, 32'd0);
      checkOutput({tag, ".idle_busy"}, {31'b0, busy}, 32'd0);
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, ".busy"}, {31'b0, busy}, 32'd0);
      checkOutput({tag, ".done"}, {31'b0, done}, 32'd0);
      checkOutput({tag, ".rd_we"}, {31'b0, rd_we}, 32'd0);
      checkOutput({tag, ".rd_data"}, rd_data, 32'd0);
      checkOutput({tag, ".redirect"}, {31'b0, redirect}, 32'd0);
      checkOutput({tag, ".redirect_pc"}, redirect_pc, 32'd0);
      checkOutput({tag, ".illegal"}, {31'b0, illegal}, 32'd0);
      checkOutput({tag, ".csr_addr"}, {20'b0, csr_addr}, 32'd0);
      checkOutput({tag, ".wr_addr"}, {20'b0, wr_addr}, 32'd0);
      checkOutput({tag, ".wr_data"}, wr_data, 32'd0);
      checkOutput({tag, ".wcsr_n"}, {31'b0, wcsr_n}, 32'd1);
      checkOutput({tag, ".ecall_o"}, {31'b0, ecall_o}, 32'd0);
      checkOutput({tag, ".mret_o"}, {31'b0, mret_o}, 32'd0);
      checkOutput({tag, ".epc_out"}, epc_out, 32'd0);
   endtask

   initial begin
      logic [11:0] legal_list [8];
      logic [31:0] mtvec_before;
      int          w0;
      logic [2:0]  ro;
      logic [11:0] rc;
      legal_list = '{12'h300, 12'h304, 12'h305, 12'h340,
                     12'h341, 12'h342, 12'h343, 12'h344};
      tests = 0; fails = 0; wr_cnt = 0; ecall_cnt = 0; mret_cnt = 0;
      last_wr_addr = '0; last_wr_data = '0; last_epc = '0;
      for (int i = 0; i < 4096; i++) csr_mem[i] = 32'h0;
      csr_mem[12'h300] = 32'h0000_1888;
      reset = 1'b1; start = 1'b0; op = '0; imm_sel = 1'b0; csr = '0;
      rs1_idx = '0; rs1_data = '0; uimm = '0; pc = '0;
      tick(); tick();
      checkResetState("reset");
      reset = 1'b0;
      tick();

      applyStimulus("csrrs_mstatus", OP_RS, 1'b0, 12'h300, 5'd5, 32'h8, 5'd0, 32'h0, 1'b0);
      applyStimulus("csrrc_x0", OP_RC, 1'b0, 12'h300, 5'd0, 32'hFFFF_FFFF, 5'd0, 32'h0, 1'b0);
      applyStimulus("csrrwi_mepc", OP_RW, 1'b1, 12'h341, 5'd9, 32'h0, 5'h1C, 32'h0, 1'b0);
      applyStimulus("csrrw_mepc", OP_RW, 1'b0, 12'h341, 5'd3, 32'h0, 5'd0, 32'h0, 1'b0);
      csr_mem[12'h305] = 32'h0000_0103;
      applyStimulus("ecall", OP_ECALL, 1'b0, 12'h0, 5'd0, 32'h0, 5'd0, 32'h40, 1'b0);
      csr_mem[12'h341] = 32'h0000_0044;
      applyStimulus("mret", OP_MRET, 1'b0, 12'h0, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0);
      applyStimulus("csrrw_c00", OP_RW, 1'b0, 12'hC00, 5'd1, 32'h5, 5'd0, 32'h0, 1'b0);
      applyStimulus("bad_op", 3'b111, 1'b0, 12'h300, 5'd1, 32'h5, 5'd0, 32'h0, 1'b0);
      applyStimulus("csrrsi_zero", OP_RS, 1'b1, 12'h300, 5'd7, 32'h0, 5'd0, 32'h0, 1'b0);

      // Reset landing in CSR_RD must abort without any write reaching mtvec
      mtvec_before = csr_mem[12'h305];
      w0 = wr_cnt;
      start = 1'b1; op = OP_RW; imm_sel = 1'b0; csr = 12'h305;
      rs1_idx = 5'd4; rs1_data = 32'hDEAD_0000;
      @(posedge clk); #1;
      start = 1'b0;
      tick();
      checkOutput("abort.csr_addr", {20'b0, csr_addr}, 32'h305);
      reset = 1'b1;
      #1;
      checkResetState("abort");
      tick(); tick();
      checkOutput("abort.writes", wr_cnt - w0, 0);
      checkOutput("abort.mtvec", csr_mem[12'h305], mtvec_before);
      reset = 1'b0;
      tick();

      applyStimulus("busy_poke", OP_RW, 1'b0, 12'h342, 5'd2, 32'h1234_5678, 5'd0, 32'h0, 1'b1);

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 9))
            0, 1:    ro = OP_RW;
            2, 3:    ro = OP_RS;
            4, 5:    ro = OP_RC;
            6:       ro = OP_ECALL;
            7:       ro = OP_MRET;
            8:       ro = 3'b000;
            default: ro = 3'($urandom_range(6, 7));
         endcase
         rc = ($urandom_range(0, 3) != 0) ? legal_list[$urandom_range(0, 7)]
                                         : 12'($urandom);
         applyStimulus("random", ro, 1'($urandom), rc,
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                       $urandom,
                       ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom),
                       $urandom, 1'($urandom_range(0, 4) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
